// File: rtl/axi_tx_channel.sv
// ----------------------------------------------------------------------------
// AxiTxChannel: transmit end of a single-beat VALID/READY channel.
//
// Words pushed by the upper module are buffered in a DEPTH-entry FIFO and
// presented one at a time on VALID/xDATA. The FIFO head is offered until the
// receiver takes it with READY, so back-pressure simply stalls the head.
//
// Parameters
//   WIDTH        data word width in bits (>= 1)
//   DEPTH        FIFO entries, power of two, >= 2
//
// Ports
//   ACLK         clock, all state changes on the rising edge
//   ARESETn      asynchronous active-low reset
//   VALID        bus VALID, driven straight from a register
//   READY        bus READY from the receiver
//   xDATA        bus data, always the FIFO head entry
//   tx_data      word from the upper module
//   tx_push      write tx_data into the FIFO this cycle
//   tx_full      FIFO holds DEPTH entries
//   tx_empty     FIFO holds no entries
//   tx_count     current occupancy, 0..DEPTH
//   tx_done      one-cycle pulse the cycle after a handshake
//   tx_overflow  one-cycle pulse the cycle after a push was dropped
// ----------------------------------------------------------------------------
module axi_tx_channel #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    output logic                       VALID,
    input  logic                       READY,
    output logic [WIDTH-1:0]           xDATA,
    input  logic [WIDTH-1:0]           tx_data,
    input  logic                       tx_push,
    output logic                       tx_full,
    output logic                       tx_empty,
    output logic [$clog2(DEPTH):0]     tx_count,
    output logic                       tx_done,
    output logic                       tx_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_IDLE = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_valid;
    logic               r_done;
    logic               r_overflow;
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               w_full;
    logic               w_pushAcc;
    logic               w_pop;
    logic [CNT_W-1:0]   w_countNext;

    // Full/empty come from the registered count, so a push into a full FIFO
    // is dropped even when the head leaves on the same edge.
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_pushAcc = tx_push && !w_full;
    assign w_pop     = r_valid && READY;

    always_comb begin
        w_countNext = r_count;
        if (w_pushAcc && !w_pop) begin
            w_countNext = r_count + CNT_W'(1);
        end else if (!w_pushAcc && w_pop) begin
            w_countNext = r_count - CNT_W'(1);
        end
    end

    // Control state, pointers, occupancy and the registered status pulses.
    // VALID is a register set on the edge that leaves the FSM in SEND, so it
    // never follows READY combinationally and holds until the handshake.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state    <= ST_RST;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
        end else begin
            r_done     <= w_pop;
            r_overflow <= tx_push && w_full;
            r_count    <= w_countNext;
            if (w_pushAcc) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case (r_state)
                // One guaranteed idle edge after reset release; a push taken
                // here is only seen as occupancy once the FSM sits in IDLE.
                ST_RST: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
                ST_IDLE: begin
                    if (w_countNext != '0) begin
                        r_state <= ST_SEND;
                        r_valid <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (w_countNext == '0) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_RST;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Storage needs no reset: entries are only observed after being written.
    always_ff @(posedge ACLK) begin
        if (w_pushAcc) begin
            r_mem[r_wrPtr] <= tx_data;
        end
    end

    assign VALID       = r_valid;
    assign xDATA       = r_mem[r_rdPtr];
    assign tx_full     = w_full;
    assign tx_empty    = (r_count == '0);
    assign tx_count    = r_count;
    assign tx_done     = r_done;
    assign tx_overflow = r_overflow;

endmodule

// File: tb/tb_axi_tx_channel.sv
// ----------------------------------------------------------------------------
// tb_axi_tx_channel: self-checking bench for axi_tx_channel.
//
// A queue-based model tracks what the channel must show on every cycle; a
// compare process checks the DUT against it on each falling clock edge.
// Directed sequences pin the model with literal expectations, then a random
// phase exercises push/READY interleavings, wrap-around and resets.
// ----------------------------------------------------------------------------
module tb_axi_tx_channel;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             ACLK;
    logic             ARESETn;
    logic             VALID;
    logic             READY;
    logic [WIDTH-1:0] xDATA;
    logic [WIDTH-1:0] tx_data;
    logic             tx_push;
    logic             tx_full;
    logic             tx_empty;
    logic [2:0]       tx_count;
    logic             tx_done;
    logic             tx_overflow;

    int errors = 0;
    int checks = 0;

    axi_tx_channel #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .VALID       (VALID),
        .READY       (READY),
        .xDATA       (xDATA),
        .tx_data     (tx_data),
        .tx_push     (tx_push),
        .tx_full     (tx_full),
        .tx_empty    (tx_empty),
        .tx_count    (tx_count),
        .tx_done     (tx_done),
        .tx_overflow (tx_overflow)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Behavioural model: the FIFO is a queue, VALID is "queue non-empty"
    // except on the first edge after reset release, which never raises it.
    logic [WIDTH-1:0] modelQ[$];
    bit               expValid    = 1'b0;
    bit               expDone     = 1'b0;
    bit               expOverflow = 1'b0;
    bit               firstEdge   = 1'b1;
    bit               modelPop;
    bit               modelAcc;

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            modelQ.delete();
            expValid    = 1'b0;
            expDone     = 1'b0;
            expOverflow = 1'b0;
            firstEdge   = 1'b1;
        end else begin
            modelPop = expValid && READY;
            modelAcc = tx_push && (modelQ.size() < DEPTH);
            if (modelPop) void'(modelQ.pop_front());
            if (modelAcc) modelQ.push_back(tx_data);
            expDone     = modelPop;
            expOverflow = tx_push && !modelAcc;
            expValid    = !firstEdge && (modelQ.size() != 0);
            firstEdge   = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Compare process: DUT outputs against the model on every falling edge.
    always @(negedge ACLK) begin
        checkOutput("VALID", 32'(VALID), 32'(expValid));
        checkOutput("tx_count", 32'(tx_count), 32'(modelQ.size()));
        checkOutput("tx_full", 32'(tx_full), 32'(modelQ.size() == DEPTH));
        checkOutput("tx_empty", 32'(tx_empty), 32'(modelQ.size() == 0));
        checkOutput("tx_done", 32'(tx_done), 32'(expDone));
        checkOutput("tx_overflow", 32'(tx_overflow), 32'(expOverflow));
        if (expValid) checkOutput("xDATA", 32'(xDATA), 32'(modelQ[0]));
    end

    // Drive inputs just after a rising edge, then let one edge consume them.
    task automatic applyStimulus(input logic push, input logic [WIDTH-1:0] data,
                                 input logic ready);
        tx_push = push;
        tx_data = data;
        READY   = ready;
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        ARESETn = 1'b0;
        READY   = 1'b1;
        tx_push = 1'b0;
        tx_data = '0;

        // Test 1: single word with READY high
        repeat (3) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("t1_reset_valid", 32'(VALID), 32'd0);
        end
        checkOutput("t1_reset_empty", 32'(tx_empty), 32'd1);
        checkOutput("t1_reset_count", 32'(tx_count), 32'd0);
        ARESETn = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t1_rst_edge_valid", 32'(VALID), 32'd0);
        applyStimulus(1'b1, 8'hA5, 1'b1);
        checkOutput("t1_valid", 32'(VALID), 32'd1);
        checkOutput("t1_xdata", 32'(xDATA), 32'hA5);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t1_after_valid", 32'(VALID), 32'd0);
        checkOutput("t1_done", 32'(tx_done), 32'd1);
        checkOutput("t1_count", 32'(tx_count), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t1_done_drop", 32'(tx_done), 32'd0);

        // Test 2: fill with READY low, then overflow
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0);
        applyStimulus(1'b1, 8'h44, 1'b0);
        checkOutput("t2_full", 32'(tx_full), 32'd1);
        checkOutput("t2_count", 32'(tx_count), 32'd4);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            checkOutput("t2_hold_valid", 32'(VALID), 32'd1);
            checkOutput("t2_hold_xdata", 32'(xDATA), 32'h11);
        end
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("t2_overflow", 32'(tx_overflow), 32'd1);
        checkOutput("t2_ovf_count", 32'(tx_count), 32'd4);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t2_overflow_drop", 32'(tx_overflow), 32'd0);

        // Test 3: drain at one word per cycle
        checkOutput("t3_head0", 32'(xDATA), 32'h11);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t3_head1", 32'(xDATA), 32'h22);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t3_head2", 32'(xDATA), 32'h33);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t3_head3", 32'(xDATA), 32'h44);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t3_valid_low", 32'(VALID), 32'd0);
        checkOutput("t3_empty", 32'(tx_empty), 32'd1);

        // Test 4: steady push+pop at occupancy 2 across pointer wrap
        applyStimulus(1'b1, 8'h01, 1'b0);
        applyStimulus(1'b1, 8'h02, 1'b0);
        checkOutput("t4_count_start", 32'(tx_count), 32'd2);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b1);
            checkOutput("t4_count", 32'(tx_count), 32'd2);
        end
        checkOutput("t4_head", 32'(xDATA), 32'h16);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t4_head_last", 32'(xDATA), 32'h17);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t4_drained", 32'(VALID), 32'd0);

        // Test 5: push into full FIFO on the same edge as a pop
        applyStimulus(1'b1, 8'hA1, 1'b0);
        applyStimulus(1'b1, 8'hA2, 1'b0);
        applyStimulus(1'b1, 8'hA3, 1'b0);
        applyStimulus(1'b1, 8'hA4, 1'b0);
        applyStimulus(1'b1, 8'h66, 1'b1);
        checkOutput("t5_count", 32'(tx_count), 32'd3);
        checkOutput("t5_overflow", 32'(tx_overflow), 32'd1);
        checkOutput("t5_done", 32'(tx_done), 32'd1);
        checkOutput("t5_head", 32'(xDATA), 32'hA2);

        // Test 6: asynchronous reset mid-transfer
        tx_push = 1'b0;
        READY   = 1'b0;
        #2;
        ARESETn = 1'b0;
        #1;
        checkOutput("t6_async_valid", 32'(VALID), 32'd0);
        checkOutput("t6_async_count", 32'(tx_count), 32'd0);
        checkOutput("t6_async_empty", 32'(tx_empty), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        ARESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("t6_idle_valid", 32'(VALID), 32'd0);
        end
        applyStimulus(1'b1, 8'h77, 1'b1);
        checkOutput("t6_push_valid", 32'(VALID), 32'd1);
        checkOutput("t6_push_xdata", 32'(xDATA), 32'h77);
        applyStimulus(1'b0, 8'h00, 1'b1);

        // Random phase: mixed push and READY densities with occasional resets
        for (int i = 0; i < 600; i++) begin
            int pushPct;
            int readyPct;
            pushPct  = (i < 200) ? 70 : ((i < 400) ? 40 : 55);
            readyPct = (i < 200) ? 30 : ((i < 400) ? 80 : 50);
            if ($urandom_range(0, 149) == 0) begin
                ARESETn = 1'b0;
                applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
                ARESETn = 1'b1;
            end else begin
                applyStimulus(1'($urandom_range(0, 99) < pushPct), 8'($urandom),
                              1'($urandom_range(0, 99) < readyPct));
            end
        end
        repeat (DEPTH + 2) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("final_empty", 32'(tx_empty), 32'd1);

        @(negedge ACLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_tx_channel.md
Name: axi_tx_channel

Overview:
Transmit end of the single-beat VALID/READY channel. It buffers words pushed by an upper module in a DEPTH-entry FIFO and presents them one per handshake on VALID/xDATA, honouring the receiver's READY back-pressure. It is the counterpart to the channel receiver and is used wherever a master or slave sources a data or address channel.

Parameters:
WIDTH, 8, data word width in bits (≥1).
DEPTH, 4, FIFO entries; power of 2, ≥2.

Ports:
ACLK  input  1  clock; all state changes on the rising edge.
ARESETn  input  1  reset, asynchronous, active-low.
VALID  output  1  bus VALID; driven from registered state only.
READY  input  1  bus READY from the receiver.
xDATA  output  WIDTH  bus data; this is the FIFO head entry.
tx_data  input  WIDTH  word from the upper module.
tx_push  input  1  write tx_data into the FIFO this cycle.
tx_full  output  1  FIFO holds DEPTH entries.
tx_empty  output  1  FIFO holds 0 entries.
tx_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
tx_done  output  1  one-cycle pulse, registered, the cycle after a handshake.
tx_overflow  output  1  one-cycle pulse, registered, the cycle after a push is dropped.

Behaviour:
- Reset, asynchronous:
  - state=RST, wr_ptr=rd_ptr=0, count=0.
  - VALID=0, tx_empty=1, tx_full=0, tx_done=0, tx_overflow=0.
  - FIFO contents are don't-care; xDATA is don't-care while VALID=0.
- States:
  - RST: VALID=0. Pushes are accepted. Always goes to IDLE on the next edge, which gives VALID low for at least one edge after reset release.
  - IDLE: VALID=0 and count=0. Goes to SEND when a push is accepted.
  - SEND: VALID=1 and count>0. Goes to IDLE when the next count is 0; otherwise stays in SEND.
  - From RST, a push accepted in the RST cycle still goes to IDLE. SEND is entered one cycle later, since count>0 is evaluated in IDLE.
- Push accept: accepted iff tx_push && !tx_full, with tx_full sampled before the edge.
  - An accepted push writes mem[wr_ptr]; wr_ptr wraps modulo DEPTH.
  - A push into a full FIFO is dropped, even if a pop occurs in the same cycle. tx_overflow pulses the next cycle.
- Pop: a pop occurs iff VALID && READY at the rising edge.
  - rd_ptr increments, wrapping modulo DEPTH.
  - tx_done pulses for the following cycle.
- count_next = count + push_acc − pop.
  - Simultaneous accepted push and pop leaves count unchanged; state stays SEND.
- VALID never depends combinationally on READY. Once VALID=1, VALID and xDATA stay stable until the handshake; rd_ptr moves only on a handshake.
- Latency:
  - A push into an empty FIFO in IDLE gives VALID=1 with xDATA=that word on the next cycle.
  - Back-to-back: with READY held high and the FIFO non-empty, one word transfers per cycle.
- tx_full = (count==DEPTH); tx_empty = (count==0); both are decoded from the registered count.
- Reset asserted mid-transfer: VALID drops asynchronously and buffered words are discarded.

Test Plan:
1. Reset, then hold READY=1 and push 0xA5 once. Required: VALID=0 through RST. VALID=1 with xDATA=0xA5 on the cycle after the push enters IDLE. After the handshake, VALID=0, tx_done=1 for 1 cycle, and tx_count returns to 0.
2. READY=0; push 0x11,0x22,0x33,0x44. Required: tx_full=1 and tx_count=4; xDATA holds 0x11 with VALID=1 steady for 10 cycles. A 5th push of 0x55 gives tx_overflow=1 for 1 cycle and count stays 4.
3. Continue test 2 and raise READY=1 for 4 cycles. Required: xDATA=0x11,0x22,0x33,0x44 on consecutive cycles, then VALID=0 and tx_empty=1.
4. With count=2 and READY=1, push every cycle for 8 cycles. Required: count stays 2. Data emerges in push order, including across pointer wrap (>DEPTH total words).
5. With count=4, assert push(0x66) and READY=1 in the same cycle. Required: the pop occurs, the push is dropped, tx_overflow pulses, and count=3.
6. Assert ARESETn=0 with count=3 and VALID=1. Required: VALID=0 immediately (asynchronous), tx_count=0, tx_empty=1. After release, VALID stays 0 until the next push.
